// File: rtl/hello_pkg.sv
// Shared definitions for the "Hello, World! \r\n" UART receive checker:
// the expected message, its length and the receiver state encoding.
package hello_pkg;

  localparam int MSG_LEN = 16;
  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  // First character sits in the most significant byte.
  localparam logic [MSG_LEN*8-1:0] MSG = {
    8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h57,
    8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h20, 8'h0D, 8'h0A
  };

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  function automatic logic [7:0] msgByte(input logic [3:0] idx);
    return MSG[(MSG_LEN - 1 - int'(idx)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// Fixed-baud 8N1 UART receiver with a two-flop input synchroniser.
// Emits a one-cycle strobe per good byte, or a framing-error strobe.
module uart_rx_8n1
  import hello_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_uart,
  output logic       o_rx_stb,
  output logic [7:0] o_rx_data,
  output logic       o_frame_err
);

  localparam logic [23:0] HALF_LOAD = 24'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [23:0] FULL_LOAD = 24'(CLOCKS_PER_BAUD - 1);

  logic        sync1_q, sync2_q;
  rx_state_e   state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        rxStb_q, rxStb_d;
  logic        frameErr_q, frameErr_d;
  logic [7:0]  rxData_q, rxData_d;
  logic        line;
  logic        expired;

  assign line    = sync2_q;
  assign expired = (cnt_q == '0);

  // Idle-high reset so release never looks like a start bit by itself.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_uart;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      rxStb_q    <= 1'b0;
      frameErr_q <= 1'b0;
      rxData_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      rxStb_q    <= rxStb_d;
      frameErr_q <= frameErr_d;
      rxData_q   <= rxData_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = expired ? cnt_q : cnt_q - 24'd1;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    unique case (state_q)
      IDLE: begin
        if (!line) begin
          cnt_d   = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (expired) begin
          if (line) begin
            state_d = IDLE;
          end else begin
            cnt_d    = FULL_LOAD;
            bitCnt_d = '0;
            state_d  = DATA;
          end
        end
      end
      DATA: begin
        if (expired) begin
          shift_d  = {line, shift_q[7:1]};
          cnt_d    = FULL_LOAD;
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      // Returning to IDLE mid stop bit gives half a bit of slack for clock skew.
      STOP: begin
        if (expired) begin
          state_d = line ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (line) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rxStb_d    = (state_q == STOP) && expired && line;
    frameErr_d = (state_q == STOP) && expired && !line;
    rxData_d   = rxStb_d ? shift_q : rxData_q;
  end

  assign o_rx_stb    = rxStb_q;
  assign o_rx_data   = rxData_q;
  assign o_frame_err = frameErr_q;

endmodule

// File: rtl/hello_rx_checker.sv
// Checks a received UART byte stream against the fixed hello message and
// reports matches, mismatches and framing errors with saturating counters.
module hello_rx_checker
  import hello_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_uart,
  output logic        o_rx_stb,
  output logic [7:0]  o_rx_data,
  output logic        o_frame_err,
  output logic        o_match_stb,
  output logic        o_mismatch_stb,
  output logic [15:0] o_msg_count,
  output logic [15:0] o_err_count,
  output logic        o_locked
);

  logic        rxStb;
  logic [7:0]  rxData;
  logic        frameErr;

  logic [3:0]  idx_q, idx_d;
  logic        matchStb_q, matchStb_d;
  logic        mismatchStb_q, mismatchStb_d;
  logic [15:0] msgCount_q, msgCount_d;
  logic [15:0] errCount_q, errCount_d;
  logic        locked_q, locked_d;

  uart_rx_8n1 #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_rx (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_uart      (i_uart),
    .o_rx_stb    (rxStb),
    .o_rx_data   (rxData),
    .o_frame_err (frameErr)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idx_q         <= '0;
      matchStb_q    <= 1'b0;
      mismatchStb_q <= 1'b0;
      msgCount_q    <= '0;
      errCount_q    <= '0;
      locked_q      <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      matchStb_q    <= matchStb_d;
      mismatchStb_q <= mismatchStb_d;
      msgCount_q    <= msgCount_d;
      errCount_q    <= errCount_d;
      locked_q      <= locked_d;
    end
  end

  // A wrong 'H' counts as the first byte of a new message, so resync is immediate.
  always_comb begin
    idx_d         = idx_q;
    matchStb_d    = 1'b0;
    mismatchStb_d = 1'b0;
    msgCount_d    = msgCount_q;
    errCount_d    = errCount_q;
    locked_d      = locked_q;
    if (frameErr) begin
      mismatchStb_d = 1'b1;
      errCount_d    = (errCount_q == 16'hffff) ? errCount_q : errCount_q + 16'd1;
      locked_d      = 1'b0;
      idx_d         = '0;
    end else if (rxStb) begin
      if (rxData == msgByte(idx_q)) begin
        if (idx_q == LAST_IDX) begin
          matchStb_d = 1'b1;
          msgCount_d = (msgCount_q == 16'hffff) ? msgCount_q : msgCount_q + 16'd1;
          locked_d   = 1'b1;
          idx_d      = '0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end else begin
        mismatchStb_d = 1'b1;
        errCount_d    = (errCount_q == 16'hffff) ? errCount_q : errCount_q + 16'd1;
        locked_d      = 1'b0;
        idx_d         = (rxData == msgByte(4'd0)) ? 4'd1 : 4'd0;
      end
    end
  end

  assign o_rx_stb       = rxStb;
  assign o_rx_data      = rxData;
  assign o_frame_err    = frameErr;
  assign o_match_stb    = matchStb_q;
  assign o_mismatch_stb = mismatchStb_q;
  assign o_msg_count    = msgCount_q;
  assign o_err_count    = errCount_q;
  assign o_locked       = locked_q;

endmodule

// File: tb/tb_hello_rx_checker.sv
// Self-checking bench for hello_rx_checker: directed steps plus a randomized
// stream, compared against a byte-level model of the message checker.
`timescale 1ns/1ps
module tb_hello_rx_checker;

  localparam int CPB = 8;

  logic        clock = 1'b0;
  logic        resetN;
  logic        uart;
  logic        o_rx_stb;
  logic [7:0]  o_rx_data;
  logic        o_frame_err;
  logic        o_match_stb;
  logic        o_mismatch_stb;
  logic [15:0] o_msg_count;
  logic [15:0] o_err_count;
  logic        o_locked;

  always #5 clock = ~clock;

  hello_rx_checker #(
    .CLOCKS_PER_BAUD(CPB)
  ) dut (
    .i_clk          (clock),
    .i_reset_n      (resetN),
    .i_uart         (uart),
    .o_rx_stb       (o_rx_stb),
    .o_rx_data      (o_rx_data),
    .o_frame_err    (o_frame_err),
    .o_match_stb    (o_match_stb),
    .o_mismatch_stb (o_mismatch_stb),
    .o_msg_count    (o_msg_count),
    .o_err_count    (o_err_count),
    .o_locked       (o_locked)
  );

  logic [7:0] msgTb [16] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h57,
                             8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h20, 8'h0D, 8'h0A};

  int passCount  = 0;
  int checkCount = 0;

  // Event monitor: sole writer of the observed-event tallies.
  int         rxCount       = 0;
  int         frameErrCount = 0;
  int         matchCount    = 0;
  int         mismatchCount = 0;
  int         latencyErrs   = 0;
  logic [7:0] rxBytes [$];
  logic [7:0] lastMismatchByte = 8'h00;
  logic       prevRx = 1'b0;
  logic       prevFe = 1'b0;

  always @(negedge clock) begin
    if (o_rx_stb) begin
      rxCount++;
      rxBytes.push_back(o_rx_data);
    end
    if (o_frame_err) frameErrCount++;
    if (o_match_stb) begin
      matchCount++;
      if (!prevRx) latencyErrs++;
    end
    if (o_mismatch_stb) begin
      mismatchCount++;
      lastMismatchByte = o_rx_data;
      if (!(prevRx || prevFe)) latencyErrs++;
    end
    prevRx = o_rx_stb;
    prevFe = o_frame_err;
  end

  // Snapshots of the monitor tallies taken at each reset.
  int rxBase, feBase, matchBase, mismatchBase;

  // Reference model of the checker at the byte level.
  int         mIdx, mMsg, mErr, mMatch, mMismatch, mFrameErr;
  logic       mLocked;
  logic [7:0] expBytes [$];

  task automatic modelReset();
    mIdx = 0; mMsg = 0; mErr = 0; mMatch = 0; mMismatch = 0; mFrameErr = 0;
    mLocked = 1'b0;
    expBytes.delete();
  endtask

  task automatic modelByte(input logic [7:0] b);
    expBytes.push_back(b);
    if (b == msgTb[mIdx]) begin
      if (mIdx == 15) begin
        mMatch++; mMsg++; mLocked = 1'b1; mIdx = 0;
      end else begin
        mIdx++;
      end
    end else begin
      mMismatch++; mErr++; mLocked = 1'b0;
      mIdx = (b == 8'h48) ? 1 : 0;
    end
  endtask

  task automatic modelFrameErr();
    mFrameErr++; mMismatch++; mErr++; mLocked = 1'b0; mIdx = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    resetN = 1'b0;
    uart   = 1'b1;
    repeat (5) @(negedge clock);
    resetN = 1'b1;
    modelReset();
    rxBase       = rxCount;
    feBase       = frameErrCount;
    matchBase    = matchCount;
    mismatchBase = mismatchCount;
  endtask

  // One 8N1 frame; line is left at the stop-bit level, then idles high for gap cycles.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int gap);
    uart = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart = stopBit;
    repeat (CPB) @(negedge clock);
    if (gap > 0) begin
      uart = 1'b1;
      repeat (gap) @(negedge clock);
    end
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, "_rx_count"}, rxCount - rxBase, expBytes.size());
    checkOutput({tag, "_frame_err_count"}, frameErrCount - feBase, mFrameErr);
    checkOutput({tag, "_match_count"}, matchCount - matchBase, mMatch);
    checkOutput({tag, "_mismatch_count"}, mismatchCount - mismatchBase, mMismatch);
    checkOutput({tag, "_msg_count"}, o_msg_count, mMsg);
    checkOutput({tag, "_err_count"}, o_err_count, mErr);
    checkOutput({tag, "_locked"}, o_locked, mLocked);
    checkOutput({tag, "_latency"}, latencyErrs, 0);
    for (int i = 0; i < expBytes.size(); i++) begin
      if (rxBase + i < rxBytes.size()) begin
        checkOutput({tag, "_byte"}, rxBytes[rxBase + i], expBytes[i]);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nGarbage;
    logic [7:0] b;

    // Reset state and quiet idle line.
    resetN = 1'b0;
    uart   = 1'b1;
    doReset();
    @(negedge clock);
    checkOutput("reset_rx_data", o_rx_data, 8'h00);
    checkOutput("reset_strobes", {o_rx_stb, o_frame_err, o_match_stb, o_mismatch_stb}, 4'b0000);
    checkOutput("reset_msg_count", o_msg_count, 16'h0000);
    checkOutput("reset_err_count", o_err_count, 16'h0000);
    checkOutput("reset_locked", o_locked, 1'b0);
    repeat (200) @(negedge clock);
    checkOutput("idle_no_strobes",
                (rxCount - rxBase) + (frameErrCount - feBase) +
                (matchCount - matchBase) + (mismatchCount - mismatchBase), 0);

    // Full message back-to-back.
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(msgTb[i], 1'b1, 0);
      modelByte(msgTb[i]);
    end
    repeat (20) @(negedge clock);
    checkAgainstModel("msg");

    // "Hex" then the full message.
    doReset();
    applyStimulus(8'h48, 1'b1, 0); modelByte(8'h48);
    applyStimulus(8'h65, 1'b1, 0); modelByte(8'h65);
    applyStimulus(8'h78, 1'b1, 3); modelByte(8'h78);
    repeat (10) @(negedge clock);
    checkOutput("hex_mismatch_byte", lastMismatchByte, 8'h78);
    checkOutput("hex_err_count", o_err_count, 16'h0001);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(msgTb[i], 1'b1, 0);
      modelByte(msgTb[i]);
    end
    repeat (10) @(negedge clock);
    checkOutput("hex_locked_before_match", o_locked, 1'b0);
    applyStimulus(msgTb[15], 1'b1, 0);
    modelByte(msgTb[15]);
    repeat (20) @(negedge clock);
    checkAgainstModel("hex");

    // Framing error followed by a held-low line.
    doReset();
    applyStimulus(8'h48, 1'b0, 0);
    uart = 1'b0;
    repeat (100) @(negedge clock);
    uart = 1'b1;
    repeat (40) @(negedge clock);
    modelFrameErr();
    checkAgainstModel("frame");

    // Short low glitch on an idle line, then a normal byte.
    doReset();
    repeat (10) @(negedge clock);
    uart = 1'b0;
    repeat (2) @(negedge clock);
    uart = 1'b1;
    repeat (40) @(negedge clock);
    checkOutput("glitch_no_strobes",
                (rxCount - rxBase) + (frameErrCount - feBase) + (mismatchCount - mismatchBase), 0);
    applyStimulus(8'h48, 1'b1, 20);
    modelByte(8'h48);
    checkAgainstModel("glitch");

    // Reset asserted during data bit 3 of 0x48.
    doReset();
    b = 8'h48;
    uart = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      uart = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart = b[3];
    repeat (CPB / 2) @(negedge clock);
    doReset();
    repeat (20) @(negedge clock);
    applyStimulus(8'h48, 1'b1, 20);
    modelByte(8'h48);
    checkAgainstModel("reset_mid");

    // Randomized stream: garbage bytes, occasionally corrupted messages, random gaps.
    doReset();
    for (int r = 0; r < 5; r++) begin
      nGarbage = $urandom_range(0, 3);
      for (int g = 0; g < nGarbage; g++) begin
        b = 8'($urandom_range(0, 255));
        applyStimulus(b, 1'b1, $urandom_range(0, 12));
        modelByte(b);
      end
      for (int i = 0; i < 16; i++) begin
        b = msgTb[i];
        if ($urandom_range(0, 39) == 0) b = 8'($urandom_range(0, 255));
        applyStimulus(b, 1'b1, $urandom_range(0, 12));
        modelByte(b);
      end
    end
    repeat (20) @(negedge clock);
    checkAgainstModel("random");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
